// File: rtl/wolfram_ca_pkg.sv
// Shared types and the rule-table lookup for the cellular-automaton array.
package wolfram_ca_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Rule bit 7 is the output for neighbourhood 000 and bit 0 is the output for 111.
  function automatic logic rule_lookup(input logic [7:0] rule_code,
                                       input logic       l,
                                       input logic       c,
                                       input logic       r);
    logic [2:0] idx;
    idx = 3'd7 - {l, c, r};
    return rule_code[idx];
  endfunction

endpackage

// File: rtl/wolfram_ca_next.sv
// Combinational next-generation logic: applies the rule to every cell at once.
// L is the higher-index neighbour and R the lower-index one. With WRAP=0 the
// array edges see 0; with WRAP=1 the array closes into a ring.
module wolfram_ca_next
  import wolfram_ca_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int WRAP  = 0
) (
  input  logic [WIDTH-1:0] i_cells,
  input  logic [7:0]       i_rule,
  output logic [WIDTH-1:0] o_next
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic w_l;
    logic w_r;

    if (i == WIDTH-1) begin : g_l_edge
      if (WRAP != 0) begin : g_ring
        assign w_l = i_cells[0];
      end else begin : g_zero
        assign w_l = 1'b0;
      end
    end else begin : g_l_inner
      assign w_l = i_cells[i+1];
    end

    if (i == 0) begin : g_r_edge
      if (WRAP != 0) begin : g_ring
        assign w_r = i_cells[WIDTH-1];
      end else begin : g_zero
        assign w_r = 1'b0;
      end
    end else begin : g_r_inner
      assign w_r = i_cells[i-1];
    end

    assign o_next[i] = rule_lookup(i_rule, w_l, i_cells[i], w_r);
  end

endmodule

// File: rtl/wolfram_ca_array.sv
// One-dimensional elementary cellular automaton that runs a programmed number
// of generations from a seed, with a hold input that pauses evolution.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for start; cells and gen_count keep the last result
//   S_RUN  | one generation per cycle unless hold is high
//   S_DONE | single-cycle done pulse, then back to S_IDLE
module wolfram_ca_array
  import wolfram_ca_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8,
  parameter int WRAP  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       rule,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] gens,
  input  logic             hold,
  output logic [WIDTH-1:0] cells,
  output logic [CNT_W-1:0] gen_count,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cells;
  logic [CNT_W-1:0] r_gen;
  logic [CNT_W-1:0] r_target;
  logic [7:0]       r_rule;
  logic [WIDTH-1:0] w_next;
  logic [CNT_W-1:0] w_gen_inc;
  logic             w_load;
  logic             w_step;

  wolfram_ca_next #(
    .WIDTH (WIDTH),
    .WRAP  (WRAP)
  ) u_next (
    .i_cells (r_cells),
    .i_rule  (r_rule),
    .o_next  (w_next)
  );

  assign w_gen_inc = r_gen + {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state decode; the final increment and the move to S_DONE share one edge
  // so gen_count can never pass the target.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = (gens == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (!hold) begin
          w_step = 1'b1;
          if (w_gen_inc == r_target) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: capture the run parameters on start, then advance one generation per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cells  <= '0;
      r_gen    <= '0;
      r_target <= '0;
      r_rule   <= '0;
    end else if (w_load) begin
      r_cells  <= seed;
      r_gen    <= '0;
      r_target <= gens;
      r_rule   <= rule;
    end else if (w_step) begin
      r_cells  <= w_next;
      r_gen    <= w_gen_inc;
    end
  end

  assign cells     = r_cells;
  assign gen_count = r_gen;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_wolfram_ca_array.sv
// Bench for wolfram_ca_array: one non-wrapping and one ring instance share the
// stimulus; expected end-of-run results are queued at start and checked on done.
module tb_wolfram_ca_array;

  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          hold  = 1'b0;
  logic [7:0]    rule  = '0;
  logic [W-1:0]  seed  = '0;
  logic [CW-1:0] gens  = '0;

  logic [W-1:0]  cells_a, cells_b;
  logic [CW-1:0] gc_a, gc_b;
  logic          busy_a, busy_b, done_a, done_b;

  wolfram_ca_array #(.WIDTH(W), .CNT_W(CW), .WRAP(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .rule(rule), .seed(seed),
    .gens(gens), .hold(hold), .cells(cells_a), .gen_count(gc_a),
    .busy(busy_a), .done(done_a)
  );

  wolfram_ca_array #(.WIDTH(W), .CNT_W(CW), .WRAP(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .rule(rule), .seed(seed),
    .gens(gens), .hold(hold), .cells(cells_b), .gen_count(gc_b),
    .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]  ca;
    logic [W-1:0]  cb;
    logic [CW-1:0] gc;
    int            dcyc;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] model_step(input logic [W-1:0] c, input logic [7:0] rl,
                                               input bit wrap);
    logic [W-1:0] n;
    logic l, r;
    int k;
    n = '0;
    for (int i = 0; i < W; i++) begin
      if (i == W-1) l = wrap ? c[0] : 1'b0;
      else          l = c[i+1];
      if (i == 0)   r = wrap ? c[W-1] : 1'b0;
      else          r = c[i-1];
      k = 7 - int'({l, c[i], r});
      n[i] = rl[k];
    end
    return n;
  endfunction

  task automatic push_exp(input logic [7:0] rl, input logic [W-1:0] sd, input int g,
                          input int lat, input int s);
    exp_t e;
    e.ca = sd;
    e.cb = sd;
    for (int j = 0; j < g; j++) begin
      e.ca = model_step(e.ca, rl, 1'b0);
      e.cb = model_step(e.cb, rl, 1'b1);
    end
    e.gc   = CW'(g);
    e.dcyc = s + lat;
    sb.push_back(e);
  endtask

  // Called just after a falling edge; returns one cycle later with the inputs scrambled.
  task automatic do_start(input logic [7:0] rl, input logic [W-1:0] sd, input int g,
                          input int lat);
    start = 1'b1;
    rule  = rl;
    seed  = sd;
    gens  = CW'(g);
    push_exp(rl, sd, g, lat, cyc);
    @(negedge clk);
    start = 1'b0;
    rule  = ~rl;
    seed  = ~sd;
    gens  = CW'(g + 7);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("run_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clk);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && (done_a || done_b)) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'({done_a, done_b}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done_a",     32'(done_a), 32'd1);
        chk("done_b",     32'(done_b), 32'd1);
        chk("cells_wrap0", 32'(cells_a), 32'(e.ca));
        chk("cells_wrap1", 32'(cells_b), 32'(e.cb));
        chk("gen_count_a", 32'(gc_a), 32'(e.gc));
        chk("gen_count_b", 32'(gc_b), 32'(e.gc));
        chk("done_latency", 32'(cyc), 32'(e.dcyc));
        chk("busy_in_done", 32'(busy_a), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_cells", 32'(cells_a), 32'd0);
    chk("rst_gc",    32'(gc_a), 32'd0);
    chk("rst_busy",  32'(busy_a), 32'd0);
    chk("rst_done",  32'(done_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // gens=1, inputs changed right after acceptance
    do_start(8'hA9, 8'h01, 1, 2);
    wait_idle(50);

    // gens=2, first generation observed mid-run
    do_start(8'hA9, 8'h00, 2, 3);
    @(negedge clk);
    chk("gen1_cells_wrap1", 32'(cells_b), 32'hFF);
    chk("gen1_count",       32'(gc_b), 32'd1);
    wait_idle(50);

    // identity rule with a three-cycle hold
    do_start(8'h33, 8'h5A, 5, 9);
    @(negedge clk);
    hold = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("hold_gc",    32'(gc_a), 32'd1);
      chk("hold_cells", 32'(cells_a), 32'h5A);
      chk("hold_busy",  32'(busy_a), 32'd1);
    end
    hold = 1'b0;
    wait_idle(50);

    // gens=0: straight to DONE
    chk("idle_busy", 32'(busy_a), 32'd0);
    do_start(8'h1E, 8'hC3, 0, 1);
    chk("zero_busy_done", 32'(busy_a), 32'd1);
    @(negedge clk);
    chk("zero_busy_after", 32'(busy_a), 32'd0);
    chk("zero_done_after", 32'(done_a), 32'd0);
    wait_idle(10);

    // asynchronous reset mid-run
    do_start(8'h1E, 8'h0F, 20, 21);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cells_a", 32'(cells_a), 32'd0);
    chk("arst_cells_b", 32'(cells_b), 32'd0);
    chk("arst_gc",      32'(gc_a), 32'd0);
    chk("arst_busy",    32'(busy_a), 32'd0);
    chk("arst_done",    32'(done_a), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("idle_after_rst", 32'(busy_a), 32'd0);
    do_start(8'h96, 8'h81, 4, 5);
    wait_idle(50);

    // start held high: second run accepted in the IDLE cycle after DONE
    start = 1'b1;
    rule  = 8'h6E;
    seed  = 8'h24;
    gens  = 8'd3;
    push_exp(8'h6E, 8'h24, 3, 4, cyc);
    push_exp(8'h6E, 8'h24, 3, 9, cyc);
    repeat (5) @(negedge clk);
    chk("b2b_idle_gap", 32'(busy_a), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_rerun_busy", 32'(busy_a), 32'd1);
    wait_idle(50);

    // assorted rules and seeds
    for (int t = 0; t < 6; t++) begin
      logic [7:0]   rl;
      logic [W-1:0] sd;
      int           g;
      rl = 8'($urandom);
      sd = W'($urandom);
      g  = int'($urandom_range(1, 12));
      do_start(rl, sd, g, 1 + g);
      wait_idle(50);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wolfram_ca_array.md
WOLFRAM_CA_ARRAY -- requirements
Module: wolfram_ca_array

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16, as the number of cells (minimum 3).
REQ-002 The block SHALL take parameter CNT_W, default 8, as the width of the generation counter and target.
REQ-003 The block SHALL take parameter WRAP, default 0; 0 means out-of-range neighbours read 0, and 1 means the array is a ring.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: request to begin a run; sampled only in IDLE.
REQ-007 The block SHALL have port rule, input, 8 bits: 3-input truth-table code; latched at an accepted start.
REQ-008 The block SHALL have port seed, input, WIDTH bits: initial cell values; latched at an accepted start.
REQ-009 The block SHALL have port gens, input, CNT_W bits: number of generations to run; latched at an accepted start.
REQ-010 The block SHALL have port hold, input, 1 bit: while high in RUN, freezes cells and counter.
REQ-011 The block SHALL have port cells, output, WIDTH bits: current cell register.
REQ-012 The block SHALL have port gen_count, output, CNT_W bits: generations completed in the current or last run.
REQ-013 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse at end of run.

Function
REQ-015 Rule encoding SHALL match the team's truth-table convention: next = rule[7 - {L,C,R}], so rule bit 7 is the output for row 000 and bit 0 is the output for row 111.
REQ-016 For cell i, C SHALL be cells[i], L SHALL be cells[i+1], and R SHALL be cells[i-1].
REQ-017 Neighbour L of cell WIDTH-1 and neighbour R of cell 0 SHALL be 0 when WRAP=0, and cells[0] and cells[WIDTH-1] respectively when WRAP=1.
REQ-018 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-019 In IDLE, start=1 SHALL load cells<=seed, latch rule and gens, and set gen_count<=0.
REQ-020 After an accepted start, the FSM SHALL enter DONE if gens==0 and RUN otherwise.
REQ-021 In RUN with hold=0, all cells SHALL update simultaneously to the next generation, and gen_count SHALL increment by 1, each cycle.
REQ-022 In RUN, when the increment makes gen_count equal the latched target, the FSM SHALL go to DONE on that same edge.
REQ-023 In RUN with hold=1, cells, gen_count and state SHALL all be unchanged.
REQ-024 In DONE, done SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE; cells and gen_count SHALL hold their final values.
REQ-025 Run latency SHALL be 1 + gens + (number of hold cycles) clock cycles from start to the done pulse.
REQ-026 start SHALL be ignored in RUN and DONE, and changes to rule, seed or gens during a run SHALL have no effect.
REQ-027 A start in the IDLE cycle immediately after DONE SHALL be accepted normally (back-to-back runs).
REQ-028 gen_count SHALL never exceed the latched target, and no wrap-around SHALL be possible because the run ends at the target.

Reset
REQ-029 While rst_n=0, the block SHALL immediately force state=IDLE, cells=0, gen_count=0, busy=0, done=0 and latched rule/target=0, independent of clk.
REQ-030 Reset asserted mid-run SHALL abort the run with no done pulse, and after release the block SHALL wait in IDLE for start.

Structure
REQ-031 Package wolfram_ca_pkg SHALL hold the FSM state enum and a rule-lookup function (rule, L, C, R) -> bit.
REQ-032 A sub-module wolfram_ca_next (combinational: cells, rule -> next cells, parametrised by WIDTH and WRAP) SHALL hold the neighbourhood logic; the top SHALL hold the FSM, counter and registers.

Verification
REQ-033 Bench case, WIDTH=8, WRAP=0, rule=0xA9, seed=0x01, gens=1: done pulse SHALL occur 2 cycles after start, with cells=0xFD and gen_count=1.
REQ-034 Bench case, WIDTH=8, WRAP=1, rule=0xA9, seed=0x00, gens=2: cells SHALL be 0xFF after generation 1 and 0xFF after generation 2, with gen_count=2.
REQ-035 Bench case, rule=0x33 (identity), seed=0x5A, gens=5, hold high for 3 cycles mid-run: cells SHALL stay 0x5A, and done SHALL arrive 9 cycles after start.
REQ-036 Bench case, gens=0, seed=0xC3: done SHALL pulse 1 cycle after start, with cells=0xC3, gen_count=0 and busy high only in DONE.
REQ-037 Bench case, rst_n dropped asynchronously mid-run: all outputs SHALL be 0 at once, no done pulse SHALL follow, and a new start after release SHALL complete correctly.
REQ-038 Bench case, start held high continuously while busy: it SHALL be ignored during RUN and DONE, and a second run SHALL begin in the cycle after DONE.
